// File: rtl/wash_pkg.sv
// Shared encodings and default timing constants for the washer timer,
// its washer FSM neighbour and the bench.
package wash_pkg;

   localparam logic [1:0] PROG_QUICK  = 2'b00;
   localparam logic [1:0] PROG_NORMAL = 2'b01;
   localparam logic [1:0] PROG_HEAVY  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_WASH,
      ST_WASH_EXP,
      ST_SPIN,
      ST_SPIN_EXP
   } timer_state_e;

   localparam int DEF_TICK_DIV = 1000;
   localparam int DEF_T_QUICK  = 100;
   localparam int DEF_T_NORMAL = 200;
   localparam int DEF_T_HEAVY  = 400;
   localparam int DEF_T_SPIN   = 50;

   // A zero duration would never expire through the 1->0 tick, so it becomes 1.
   function automatic int clamp1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/wash_tick_prescaler.sv
// Divides clk into one-cycle ticks every TICK_DIV un-held cycles.
module wash_tick_prescaler #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic hold,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   if (TICK_DIV < 1) begin : g_bad_div
      $error("TICK_DIV must be at least 1");
   end

   logic [PW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (!hold)
         cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
   end

   assign tick = (cnt == LAST) && !hold;

endmodule

// File: rtl/wash_cycle_timer.sv
// Wash-pass and spin timer feeding cycle_timeout/spin_timeout to the washer FSM.
module wash_cycle_timer
   import wash_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int T_QUICK  = DEF_T_QUICK,
   parameter int T_NORMAL = DEF_T_NORMAL,
   parameter int T_HEAVY  = DEF_T_HEAVY,
   parameter int T_SPIN   = DEF_T_SPIN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       prog_sel,
   input  logic             motor,
   input  logic             spin_en,
   input  logic             done,
   input  logic             pause,
   input  logic             abort,
   output logic             cycle_timeout,
   output logic             spin_timeout,
   output logic             busy,
   output logic [1:0]       prog_active,
   output logic [1:0]       pass_cnt,
   output logic [CNT_W-1:0] remaining
);

   localparam longint MAX_DUR = (longint'(1) << CNT_W) - 1;

   if (clamp1(T_QUICK) > MAX_DUR || clamp1(T_NORMAL) > MAX_DUR ||
       clamp1(T_HEAVY) > MAX_DUR || clamp1(T_SPIN) > MAX_DUR) begin : g_bad_dur
      $error("duration parameter does not fit in CNT_W");
   end

   localparam logic [CNT_W-1:0] DUR_Q = CNT_W'(clamp1(T_QUICK));
   localparam logic [CNT_W-1:0] DUR_N = CNT_W'(clamp1(T_NORMAL));
   localparam logic [CNT_W-1:0] DUR_H = CNT_W'(clamp1(T_HEAVY));
   localparam logic [CNT_W-1:0] DUR_S = CNT_W'(clamp1(T_SPIN));

   timer_state_e     state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             cto_q, cto_d, sto_q, sto_d, busy_q;
   logic [1:0]       prog_q, prog_d, pass_q, pass_d;
   logic [CNT_W-1:0] wash_dur;
   logic             tick, counting;

   // Prescaler sits at zero outside the counting states, so each phase starts aligned.
   assign counting = (state_q == ST_WASH) || (state_q == ST_SPIN);

   wash_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk   (clk),
      .rst   (rst),
      .clear (!counting),
      .hold  (pause),
      .tick  (tick)
   );

   always_comb begin
      case (prog_q)
         PROG_QUICK: wash_dur = DUR_Q;
         PROG_HEAVY: wash_dur = DUR_H;
         default:    wash_dur = DUR_N;
      endcase
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cto_d   = cto_q;
      sto_d   = sto_q;
      prog_d  = prog_q;
      pass_d  = pass_q;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_ARMED;
            prog_d  = (prog_sel == 2'b11) ? PROG_NORMAL : prog_sel;
            pass_d  = 2'd0;
         end
         ST_ARMED: if (motor) begin
            state_d = ST_WASH;
            rem_d   = wash_dur;
         end else if (spin_en) begin
            state_d = ST_SPIN;
            rem_d   = DUR_S;
         end
         ST_WASH: if (tick) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
               state_d = ST_WASH_EXP;
               cto_d   = 1'b1;
            end
         end
         ST_WASH_EXP: if (!motor) begin
            state_d = ST_ARMED;
            cto_d   = 1'b0;
            pass_d  = (pass_q == 2'd3) ? pass_q : pass_q + 2'd1;
         end
         ST_SPIN: if (tick) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
               state_d = ST_SPIN_EXP;
               sto_d   = 1'b1;
            end
         end
         ST_SPIN_EXP: if (done) begin
            state_d = ST_IDLE;
            sto_d   = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
      // Abort wins over everything; program and pass count stay for diagnosis.
      if (abort) begin
         state_d = ST_IDLE;
         rem_d   = '0;
         cto_d   = 1'b0;
         sto_d   = 1'b0;
         prog_d  = prog_q;
         pass_d  = pass_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         cto_q   <= 1'b0;
         sto_q   <= 1'b0;
         busy_q  <= 1'b0;
         prog_q  <= 2'b00;
         pass_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cto_q   <= cto_d;
         sto_q   <= sto_d;
         busy_q  <= (state_d != ST_IDLE);
         prog_q  <= prog_d;
         pass_q  <= pass_d;
      end
   end

   assign cycle_timeout = cto_q;
   assign spin_timeout  = sto_q;
   assign busy          = busy_q;
   assign prog_active   = prog_q;
   assign pass_cnt      = pass_q;
   assign remaining     = rem_q;

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Directed bench for wash_cycle_timer with a short tick and short durations.
module tb_wash_cycle_timer;

   localparam int CNT_W = 16;
   localparam int TD = 4, TQ = 3, TN = 5, TH = 7, TS = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0, start = 1'b0, motor = 1'b0, spin_en = 1'b0;
   logic             done = 1'b0, pause = 1'b0, abort = 1'b0;
   logic [1:0]       prog_sel = 2'b00;
   logic             cycle_timeout, spin_timeout, busy;
   logic [1:0]       prog_active, pass_cnt;
   logic [CNT_W-1:0] remaining;

   int total = 0;
   int bad   = 0;

   wash_cycle_timer #(
      .CNT_W(CNT_W), .TICK_DIV(TD), .T_QUICK(TQ), .T_NORMAL(TN),
      .T_HEAVY(TH), .T_SPIN(TS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .prog_sel(prog_sel),
      .motor(motor), .spin_en(spin_en), .done(done), .pause(pause),
      .abort(abort), .cycle_timeout(cycle_timeout),
      .spin_timeout(spin_timeout), .busy(busy), .prog_active(prog_active),
      .pass_cnt(pass_cnt), .remaining(remaining)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if ({cycle_timeout, spin_timeout, busy, prog_active, pass_cnt} !== 7'd0 || remaining !== '0) begin
         bad++;
         $display("FAIL reset: got cto=%b sto=%b busy=%b prog=%b pass=%0d rem=%0d, want all 0",
                  cycle_timeout, spin_timeout, busy, prog_active, pass_cnt, remaining);
      end
   endtask

   task automatic test_quick();
      start = 1'b1; prog_sel = 2'b00; motor = 1'b1;
      step();
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || remaining !== '0) begin
         bad++; $display("FAIL quick_armed: busy=%b rem=%0d, want 1/0", busy, remaining);
      end
      step();
      total++;
      if (remaining !== 16'd3) begin
         bad++; $display("FAIL quick_entry: rem=%0d, want 3", remaining);
      end
      for (int i = 1; i <= 12; i++) begin
         step();
         total++;
         if (remaining !== 16'(3 - i / 4) || cycle_timeout !== (i == 12)) begin
            bad++;
            $display("FAIL quick_count[%0d]: rem=%0d cto=%b, want %0d/%b",
                     i, remaining, cycle_timeout, 3 - i / 4, i == 12);
         end
      end
      step();
      total++;
      if (cycle_timeout !== 1'b1) begin
         bad++; $display("FAIL quick_hold: cto=%b, want 1", cycle_timeout);
      end
      motor = 1'b0;
      step();
      total++;
      if (cycle_timeout !== 1'b0 || pass_cnt !== 2'd1 || busy !== 1'b1) begin
         bad++; $display("FAIL quick_release: cto=%b pass=%0d busy=%b, want 0/1/1",
                         cycle_timeout, pass_cnt, busy);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || pass_cnt !== 2'd1 || prog_active !== 2'b00) begin
         bad++; $display("FAIL quick_abort: busy=%b pass=%0d prog=%b, want 0/1/00",
                         busy, pass_cnt, prog_active);
      end
   endtask

   task automatic test_heavy_two_pass();
      start = 1'b1; prog_sel = 2'b10; motor = 1'b1;
      step();
      start = 1'b0;
      for (int p = 1; p <= 2; p++) begin
         motor = 1'b1;
         step();
         total++;
         if (remaining !== 16'd7 || prog_active !== 2'b10) begin
            bad++; $display("FAIL heavy_entry[%0d]: rem=%0d prog=%b, want 7/10", p, remaining, prog_active);
         end
         for (int i = 1; i <= 28; i++) begin
            step();
            if (i >= 27) begin
               total++;
               if (cycle_timeout !== (i == 28) || (i == 28 && remaining !== '0)) begin
                  bad++; $display("FAIL heavy_expiry[%0d,%0d]: cto=%b rem=%0d, want %b", p, i,
                                  cycle_timeout, remaining, i == 28);
               end
            end
         end
         motor = 1'b0;
         step();
         total++;
         if (cycle_timeout !== 1'b0 || pass_cnt !== 2'(p)) begin
            bad++; $display("FAIL heavy_pass[%0d]: cto=%b pass=%0d, want 0/%0d", p, cycle_timeout, pass_cnt, p);
         end
      end
      spin_en = 1'b1;
      step();
      total++;
      if (remaining !== 16'd2) begin
         bad++; $display("FAIL spin_entry: rem=%0d, want 2", remaining);
      end
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i >= 7) begin
            total++;
            if (spin_timeout !== (i >= 8) || cycle_timeout !== 1'b0) begin
               bad++; $display("FAIL spin_expiry[%0d]: sto=%b cto=%b, want %b/0", i, spin_timeout,
                               cycle_timeout, i >= 8);
            end
         end
      end
      done = 1'b1;
      step();
      done = 1'b0; spin_en = 1'b0;
      total++;
      if (spin_timeout !== 1'b0 || busy !== 1'b0 || remaining !== '0 || pass_cnt !== 2'd2) begin
         bad++; $display("FAIL spin_done: sto=%b busy=%b rem=%0d pass=%0d, want 0/0/0/2",
                         spin_timeout, busy, remaining, pass_cnt);
      end
   endtask

   task automatic test_pause();
      start = 1'b1; prog_sel = 2'b01; motor = 1'b1;
      step();
      start = 1'b0;
      step();
      for (int i = 1; i <= 6; i++) step();
      total++;
      if (remaining !== 16'd4) begin
         bad++; $display("FAIL pause_pre: rem=%0d, want 4", remaining);
      end
      pause = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         total++;
         if (remaining !== 16'd4 || cycle_timeout !== 1'b0) begin
            bad++; $display("FAIL pause_frozen[%0d]: rem=%0d cto=%b, want 4/0", i, remaining, cycle_timeout);
         end
      end
      pause = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         step();
         if (i >= 13) begin
            total++;
            if (cycle_timeout !== (i == 14)) begin
               bad++; $display("FAIL pause_expiry[%0d]: cto=%b, want %b", i, cycle_timeout, i == 14);
            end
         end
      end
      pause = 1'b1;
      step();
      step();
      total++;
      if (cycle_timeout !== 1'b1) begin
         bad++; $display("FAIL pause_in_exp: cto=%b, want 1", cycle_timeout);
      end
      pause = 1'b0; abort = 1'b1;
      step();
      abort = 1'b0; motor = 1'b0;
   endtask

   task automatic test_abort();
      start = 1'b1; prog_sel = 2'b00; motor = 1'b1;
      step();
      start = 1'b0;
      step();
      for (int i = 1; i <= 12; i++) step();
      motor = 1'b0;
      step();
      motor = 1'b1;
      step();
      for (int i = 1; i <= 5; i++) step();
      abort = 1'b1; start = 1'b1; prog_sel = 2'b10;
      step();
      total++;
      if (busy !== 1'b0 || cycle_timeout !== 1'b0 || spin_timeout !== 1'b0 || remaining !== '0 ||
          pass_cnt !== 2'd1 || prog_active !== 2'b00) begin
         bad++; $display("FAIL abort_edge: busy=%b cto=%b sto=%b rem=%0d pass=%0d prog=%b, want 0/0/0/0/1/00",
                         busy, cycle_timeout, spin_timeout, remaining, pass_cnt, prog_active);
      end
      abort = 1'b0; start = 1'b0; motor = 1'b0;
      step();
      total++;
      if (busy !== 1'b0 || prog_active !== 2'b00) begin
         bad++; $display("FAIL abort_idle: busy=%b prog=%b, want 0/00", busy, prog_active);
      end
   endtask

   task automatic test_prog11_and_reset();
      start = 1'b1; prog_sel = 2'b11; motor = 1'b1;
      step();
      start = 1'b0;
      total++;
      if (prog_active !== 2'b01) begin
         bad++; $display("FAIL prog11_map: prog=%b, want 01", prog_active);
      end
      step();
      for (int i = 1; i <= 20; i++) begin
         if (i == 4) begin start = 1'b1; prog_sel = 2'b00; end
         else start = 1'b0;
         step();
         total++;
         if (remaining !== 16'(5 - i / 4) || cycle_timeout !== (i == 20) || prog_active !== 2'b01) begin
            bad++; $display("FAIL prog11_count[%0d]: rem=%0d cto=%b prog=%b, want %0d/%b/01",
                            i, remaining, cycle_timeout, prog_active, 5 - i / 4, i == 20);
         end
      end
      motor = 1'b0;
      step();
      spin_en = 1'b1;
      step();
      for (int i = 1; i <= 8; i++) step();
      total++;
      if (spin_timeout !== 1'b1 || pass_cnt !== 2'd1) begin
         bad++; $display("FAIL prog11_spin: sto=%b pass=%0d, want 1/1", spin_timeout, pass_cnt);
      end
      rst = 1'b1;
      step();
      rst = 1'b0; spin_en = 1'b0;
      total++;
      if ({cycle_timeout, spin_timeout, busy, prog_active, pass_cnt} !== 7'd0 || remaining !== '0) begin
         bad++; $display("FAIL reset_mid: cto=%b sto=%b busy=%b prog=%b pass=%0d rem=%0d, want all 0",
                         cycle_timeout, spin_timeout, busy, prog_active, pass_cnt, remaining);
      end
      step();
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL reset_stays_idle: busy=%b, want 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_quick();
      test_heavy_two_pass();
      test_pause();
      test_abort();
      test_prog11_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
